// File: rtl/jump_target_unit.sv
// ----------------------------------------------------------------------------
// jump_target_unit
//
// Builds a jump/branch offset from decoded instruction fields, sign-extends it
// and adds it to the PC of the jumping instruction. CALL pushes the return
// address (pc_in + 1) onto a small circular return-address stack (RAS). RET
// pops it. One request is handled at a time through IDLE -> CALC -> RESP.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. req_ready is high only in IDLE. resp_valid is high only in RESP.
// While in RESP, target and err are held stable until resp_ready is seen.
//
// Ports:
//   clk, rst               clock (rising edge) / synchronous active-high reset
//   req_valid, req_ready   request handshake
//   mode                   00 JMP, 01 BR, 10 CALL, 11 RET
//   m, rd, rs1, imm        instruction fields forming the offset
//   pc_in                  PC of the jumping instruction
//   resp_valid, resp_ready response handshake
//   target                 computed next PC
//   err                    RAS overflow (CALL) / underflow (RET)
// ----------------------------------------------------------------------------
module jump_target_unit #(
    parameter int PC_W      = 16,
    parameter int REG_W     = 3,
    parameter int IMM_W     = 5,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       mode,
    input  logic             m,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [IMM_W-1:0] imm,
    input  logic [PC_W-1:0]  pc_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [PC_W-1:0]  target,
    output logic             err
);

    localparam int OFF_W = 1 + 2*REG_W + IMM_W;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] MODE_JMP  = 2'b00;
    localparam logic [1:0] MODE_BR   = 2'b01;
    localparam logic [1:0] MODE_CALL = 2'b10;
    localparam logic [1:0] MODE_RET  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               m_q, m_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic [REG_W-1:0]   rs1_q, rs1_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    target_q, target_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;   // next free slot; top entry is ptr_q-1

    logic [PC_W-1:0]    ras_q [RAS_DEPTH];
    logic               ras_we;
    logic [PC_W-1:0]    ras_wdata;

    logic [OFF_W-1:0]   jfield;
    logic [PC_W-1:0]    off_sext;
    logic [PC_W-1:0]    sum;
    logic [PC_W-1:0]    pc_inc;
    logic               ras_full;
    logic [PTR_W-1:0]   top_idx;

    // Offset assembly and sign extension (casts of signed values extend the sign).
    assign jfield   = {m_q, rd_q, rs1_q, imm_q};
    assign off_sext = (mode_q == MODE_BR) ? PC_W'($signed(imm_q))
                                          : PC_W'($signed(jfield));
    assign sum      = pc_q + off_sext;
    assign pc_inc   = pc_q + PC_W'(1);
    assign ras_full = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top_idx  = ptr_q - PTR_W'(1);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        m_d       = m_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        target_d  = target_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        ras_we    = 1'b0;
        ras_wdata = pc_inc;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mode_d  = mode;
                    m_d     = m;
                    rd_d    = rd;
                    rs1_d   = rs1;
                    imm_d   = imm;
                    pc_d    = pc_in;
                    state_d = CALC;
                end
            end
            CALC: begin
                target_d = sum;
                err_d    = 1'b0;
                case (mode_q)
                    MODE_CALL: begin
                        // When full, ptr_q already points at the oldest entry,
                        // so the push overwrites it and the count saturates.
                        ras_we = 1'b1;
                        ptr_d  = ptr_q + PTR_W'(1);
                        if (ras_full) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    MODE_RET: begin
                        if (cnt_q != '0) begin
                            target_d = ras_q[top_idx];
                            ptr_d    = top_idx;
                            cnt_d    = cnt_q - CNT_W'(1);
                        end else begin
                            target_d = pc_inc;
                            err_d    = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            m_q      <= 1'b0;
            rd_q     <= '0;
            rs1_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            m_q      <= m_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    // Stack contents need no reset: count==0 makes them unreachable.
    always_ff @(posedge clk) begin
        if (!rst && ras_we) begin
            ras_q[ptr_q] <= ras_wdata;
        end
    end

    // Outputs are forced inactive while rst is asserted, including the reset cycle.
    assign req_ready  = !rst && (state_q == IDLE);
    assign resp_valid = !rst && (state_q == RESP);
    assign target     = rst ? '0 : target_q;
    assign err        = !rst && err_q;

endmodule

// File: tb/tb_jump_target_unit.sv
module tb_jump_target_unit;

    localparam int PC_W  = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  mode = '0;
    logic        m = 1'b0;
    logic [2:0]  rd = '0;
    logic [2:0]  rs1 = '0;
    logic [4:0]  imm = '0;
    logic [15:0] pc_in = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] target;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    jump_target_unit #(.PC_W(16), .REG_W(3), .IMM_W(5), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mode(mode), .m(m), .rd(rd), .rs1(rs1), .imm(imm), .pc_in(pc_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .target(target), .err(err)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] ras_m[$];

    function automatic logic [15:0] add_off(input logic [1:0] md, input logic mm,
                                            input logic [2:0] r_d, input logic [2:0] r_s,
                                            input logic [4:0] im, input logic [15:0] pc);
        int off;
        if (md == 2'b01) begin
            off = int'(im);
            if (off >= 16) off -= 32;
        end else begin
            off = int'(mm) * 2048 + int'(r_d) * 256 + int'(r_s) * 32 + int'(im);
            if (mm) off -= 4096;
        end
        return 16'((int'(pc) + off + 65536) % 65536);
    endfunction

    task automatic model(input logic [1:0] md, input logic mm, input logic [2:0] r_d,
                         input logic [2:0] r_s, input logic [4:0] im, input logic [15:0] pc,
                         output logic [15:0] t, output logic e);
        e = 1'b0;
        t = add_off(md, mm, r_d, r_s, im, pc);
        if (md == 2'b10) begin
            if (ras_m.size() == DEPTH) begin
                void'(ras_m.pop_front());
                e = 1'b1;
            end
            ras_m.push_back(pc + 16'd1);
        end else if (md == 2'b11) begin
            if (ras_m.size() > 0) t = ras_m.pop_back();
            else begin
                t = pc + 16'd1;
                e = 1'b1;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ras_m.delete();
    endtask

    task automatic send(input logic [1:0] md, input logic mm, input logic [2:0] r_d,
                        input logic [2:0] r_s, input logic [4:0] im, input logic [15:0] pc,
                        input int stall, input bit poke,
                        output logic [15:0] t, output logic e);
        int w;
        @(negedge clk);
        mode = md; m = mm; rd = r_d; rs1 = r_s; imm = im; pc_in = pc;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs: they must only matter in the accept cycle.
        req_valid = 1'b0;
        mode = 2'($urandom); m = 1'($urandom); rd = 3'($urandom);
        rs1 = 3'($urandom); imm = 5'($urandom); pc_in = 16'($urandom);
        @(negedge clk);
        check("calc_resp_valid", 32'(resp_valid), 32'd0);
        check("calc_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("latency_resp_valid", 32'(resp_valid), 32'd1);
        t = target;
        e = err;
        for (int i = 0; i < stall; i++) begin
            if (poke) req_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_target", 32'(target), 32'(t));
            check("hold_err", 32'(err), 32'(e));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("back_idle_ready", 32'(req_ready), 32'd1);
        check("back_idle_valid", 32'(resp_valid), 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  md;
        logic        mm;
        logic [2:0]  r_d;
        logic [2:0]  r_s;
        logic [4:0]  im;
        logic [15:0] pc;
        logic [15:0] exp_t;
        logic        exp_e;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] md, input logic mm, input logic [2:0] r_d,
                       input logic [2:0] r_s, input logic [4:0] im, input logic [15:0] pc,
                       input logic [15:0] et, input logic ee);
        vec_t v;
        v.md = md; v.mm = mm; v.r_d = r_d; v.r_s = r_s; v.im = im; v.pc = pc;
        v.exp_t = et; v.exp_e = ee;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] t, et;
        logic        e, ee;
        logic [1:0]  md;
        logic        mm;
        logic [2:0]  rr, ss;
        logic [4:0]  ii;
        logic [15:0] pp;

        add(2'b00, 1'b1, 3'b101, 3'b010, 5'b11001, 16'h0100, 16'hFE59, 1'b0);
        add(2'b00, 1'b0, 3'b011, 3'b001, 5'b00010, 16'h1000, 16'h1322, 1'b0);
        add(2'b01, 1'b1, 3'b111, 3'b111, 5'b11001, 16'h0010, 16'h0009, 1'b0);
        add(2'b01, 1'b0, 3'b000, 3'b000, 5'b00111, 16'hFFFE, 16'h0005, 1'b0);
        add(2'b10, 1'b0, 3'b000, 3'b000, 5'b00100, 16'h0020, 16'h0024, 1'b0);
        add(2'b11, 1'b1, 3'b111, 3'b101, 5'b10101, 16'h0050, 16'h0021, 1'b0);
        add(2'b11, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0030, 16'h0031, 1'b1);
        add(2'b10, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0010, 16'h0010, 1'b0);
        add(2'b10, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0020, 16'h0020, 1'b0);
        add(2'b10, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0030, 16'h0030, 1'b0);
        add(2'b10, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0040, 16'h0040, 1'b0);
        add(2'b10, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0050, 16'h0050, 1'b1);
        add(2'b11, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0060, 16'h0051, 1'b0);
        add(2'b11, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0060, 16'h0041, 1'b0);
        add(2'b11, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0060, 16'h0031, 1'b0);
        add(2'b11, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0060, 16'h0021, 1'b0);
        add(2'b11, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0060, 16'h0061, 1'b1);

        // Reset state, including outputs during the reset cycle.
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_req_ready", 32'(req_ready), 32'd0);
        check("rst_cycle_resp_valid", 32'(resp_valid), 32'd0);
        do_reset();
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_target", 32'(target), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        foreach (tbl[i]) begin
            send(tbl[i].md, tbl[i].mm, tbl[i].r_d, tbl[i].r_s, tbl[i].im, tbl[i].pc,
                 i % 3, 1'b0, t, e);
            check($sformatf("vec%0d_target", i), 32'(t), 32'(tbl[i].exp_t));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_e));
        end

        // Backpressure with a competing request held high during RESP.
        send(2'b00, 1'b1, 3'b101, 3'b010, 5'b11001, 16'h0100, 3, 1'b1, t, e);
        check("bp_target", 32'(t), 32'hFE59);
        check("bp_err", 32'(e), 32'd0);

        // Reset during CALC of a CALL after one completed CALL.
        send(2'b10, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0080, 0, 1'b0, t, e);
        check("pre_rst_call", 32'(t), 32'h0080);
        @(negedge clk);
        mode = 2'b10; m = 1'b0; rd = '0; rs1 = '0; imm = '0; pc_in = 16'h0090;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_target", 32'(target), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        send(2'b11, 1'b0, 3'b000, 3'b000, 5'b00000, 16'h0070, 0, 1'b0, t, e);
        check("midrst_ret_target", 32'(t), 32'h0071);
        check("midrst_ret_err", 32'(e), 32'd1);

        // Randomized traffic against the queue-based model.
        do_reset();
        for (int n = 0; n < 250; n++) begin
            md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) md = 2'b10;
            mm = 1'($urandom);
            rr = 3'($urandom);
            ss = 3'($urandom);
            ii = 5'($urandom);
            pp = 16'($urandom);
            model(md, mm, rr, ss, ii, pp, et, ee);
            send(md, mm, rr, ss, ii, pp, $urandom_range(0, 2), 1'($urandom), t, e);
            check($sformatf("rnd%0d_target", n), 32'(t), 32'(et));
            check($sformatf("rnd%0d_err", n), 32'(e), 32'(ee));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
